// File: rtl/cpu_rst_n_o_pkg.sv
// Shared constants and types for the cpu_rst_n_o reset-output PIO.
//   ADDR_*  : register addresses on the 2-bit Avalon-MM address
//   CTRL_*  : bit positions in the write-only CTRL register
//   STAT_*  : bit positions in the STATUS register
//   state_e : pulse FSM state
package cpu_rst_n_o_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LEN    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_e;
endpackage

// File: rtl/cpu_rst_n_o_if.sv
// Avalon-MM slave bus bundle for cpu_rst_n_o.
//   address    : register select (2 bits)
//   chipselect : slave selected
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit registered read data (slave -> master)
interface cpu_rst_n_o_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/cpu_rst_n_o_pulse_timer.sv
// Load / decrement down-counter used to time the reset pulse.
//   clk, reset : clock, synchronous active-high reset (clears count)
//   load       : load load_val (takes priority over dec)
//   dec        : decrement, saturating at zero
//   load_val   : value to load
//   zero       : count is zero
module cpu_rst_n_o_pulse_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/cpu_rst_n_o.sv
// Avalon-MM output PIO driving a software-controlled active-low reset line.
// Supports a static level (DATA) and a timed low pulse of LEN cycles started
// through CTRL, with BUSY/DONE status.
//   clk, reset : clock, synchronous active-high reset
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port   : registered active-low reset output
// PULSE_W must be in 1..32 (LEN is written from writedata[PULSE_W-1:0]).
module cpu_rst_n_o
  import cpu_rst_n_o_pkg::*;
#(
  parameter int   PULSE_W     = 16,
  parameter int   DEFAULT_LEN = 16,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  cpu_rst_n_o_if.slave  bus,
  output logic          out_port
);
  state_e             state;
  logic               level;
  logic [PULSE_W-1:0] len;
  logic               done;
  logic               tmr_zero;

  // Write decode
  logic wr, wr_data, wr_len, wr_ctrl, wr_status;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr && (bus.address == ADDR_DATA);
  assign wr_len    = wr && (bus.address == ADDR_LEN);
  assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
  assign wr_status = wr && (bus.address == ADDR_STATUS);

  // ABORT dominates START when both are written together.
  logic start, abort, done_clr;
  assign abort    = wr_ctrl & bus.writedata[CTRL_ABORT];
  assign start    = wr_ctrl & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_ABORT];
  assign done_clr = wr_status & bus.writedata[STAT_DONE];

  // Level as it will be after this edge, so a DATA write coinciding with the
  // end of a pulse (or in IDLE) shows on out_port at the write edge.
  logic level_nxt;
  assign level_nxt = wr_data ? bus.writedata[0] : level;

  // A zero length would mean "no pulse"; store 1 instead.
  logic [PULSE_W-1:0] len_wval;
  assign len_wval = (bus.writedata[PULSE_W-1:0] == '0) ? PULSE_W'(1)
                                                        : bus.writedata[PULSE_W-1:0];

  logic tmr_load, pulse_end;
  assign tmr_load  = (state == IDLE) && start;
  assign pulse_end = (state == PULSE) && !abort && tmr_zero;

  // Counter holds LEN-1 at the START edge, so LEN low cycles elapse before
  // the zero count is seen in PULSE.
  cpu_rst_n_o_pulse_timer #(.W(PULSE_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .dec      (state == PULSE),
    .load_val (len - 1'b1),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      level    <= INIT_LEVEL;
      len      <= PULSE_W'(DEFAULT_LEN);
      done     <= 1'b0;
      out_port <= INIT_LEVEL;
    end else begin
      level <= level_nxt;
      if (wr_len) len <= len_wval;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= PULSE;
            out_port <= 1'b0;
          end else begin
            out_port <= level_nxt;
          end
        end
        PULSE: begin
          // START is ignored here; abort or terminal count ends the pulse.
          if (abort || tmr_zero) begin
            state    <= IDLE;
            out_port <= level_nxt;
          end
        end
        default: state <= IDLE;
      endcase

      // Completion set beats a coincident software clear.
      if (pulse_end)     done <= 1'b1;
      else if (done_clr) done <= 1'b0;
    end
  end

  // Read mux, registered every cycle regardless of chipselect.
  logic [31:0] rd_nxt;
  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      ADDR_DATA:   rd_nxt[0] = out_port;
      ADDR_LEN:    rd_nxt    = 32'(len);
      ADDR_STATUS: begin
        rd_nxt[STAT_BUSY] = (state == PULSE);
        rd_nxt[STAT_DONE] = done;
      end
      default:     rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_nxt;
  end

  // Upper writedata bits have no function.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.writedata};
endmodule

// File: tb/tb_cpu_rst_n_o.sv
module tb_cpu_rst_n_o;
  import cpu_rst_n_o_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic out_port;
  cpu_rst_n_o_if bus();

  cpu_rst_n_o #(.PULSE_W(16), .DEFAULT_LEN(16), .INIT_LEVEL(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          is_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_out;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end at a negedge; the op is sampled at the
  // posedge in between.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.chipselect = 1'b0;
    chk(name, bus.readdata, exp_q.pop_front());
  endtask

  // Counts cycles out_port stays low, bounded.
  task automatic measure(input int bound, output int n);
    n = 0;
    while (out_port === 1'b0 && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    vecs[0]  = '{1'b1, ADDR_DATA,   32'd1,          32'd0,      1'b1};
    vecs[1]  = '{1'b0, ADDR_DATA,   32'd0,          32'd1,      1'b1};
    vecs[2]  = '{1'b1, ADDR_LEN,    32'd0,          32'd0,      1'b1};
    vecs[3]  = '{1'b0, ADDR_LEN,    32'd0,          32'd1,      1'b1};
    vecs[4]  = '{1'b1, ADDR_LEN,    32'hABCD1234,   32'd0,      1'b1};
    vecs[5]  = '{1'b0, ADDR_LEN,    32'd0,          32'h1234,   1'b1};
    vecs[6]  = '{1'b1, ADDR_DATA,   32'hFFFFFFFE,   32'd0,      1'b0};
    vecs[7]  = '{1'b0, ADDR_DATA,   32'd0,          32'd0,      1'b0};
    vecs[8]  = '{1'b0, ADDR_CTRL,   32'd0,          32'd0,      1'b0};
    vecs[9]  = '{1'b1, ADDR_CTRL,   32'd3,          32'd0,      1'b0};
    vecs[10] = '{1'b0, ADDR_STATUS, 32'd0,          32'd0,      1'b0};
    vecs[11] = '{1'b1, ADDR_DATA,   32'd1,          32'd0,      1'b1};
    vecs[12] = '{1'b0, ADDR_STATUS, 32'd0,          32'd0,      1'b1};

    reset = 1'b1;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset values
    chk("rst_out", {31'd0, out_port}, 32'd0);
    rd("rst_data",   ADDR_DATA,   32'd0);
    rd("rst_len",    ADDR_LEN,    32'd16);
    rd("rst_ctrl",   ADDR_CTRL,   32'd0);
    rd("rst_status", ADDR_STATUS, 32'd0);

    // Register access table (includes LEN=0 -> 1, CTRL=3 no-op in IDLE)
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].wdata);
      else rd($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out", i), {31'd0, out_port}, {31'd0, vecs[i].exp_out});
    end

    // Timed pulse LEN=5, BUSY throughout, DONE after, clear
    wr(ADDR_LEN, 32'd5);
    wr(ADDR_CTRL, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("p5_low%0d", i), {31'd0, out_port}, 32'd0);
      rd($sformatf("p5_busy%0d", i), ADDR_STATUS, 32'd1);
    end
    chk("p5_high", {31'd0, out_port}, 32'd1);
    rd("p5_done", ADDR_STATUS, 32'd2);
    wr(ADDR_STATUS, 32'd2);
    rd("p5_clr", ADDR_STATUS, 32'd0);

    // LEN=0 gives a 1-cycle pulse
    wr(ADDR_LEN, 32'd0);
    wr(ADDR_CTRL, 32'd1);
    measure(10, n);
    chk("len0_pulse", n, 32'd1);

    // START during pulse is ignored
    wr(ADDR_LEN, 32'd8);
    wr(ADDR_CTRL, 32'd1);
    repeat (2) @(negedge clk);
    wr(ADDR_CTRL, 32'd1);
    measure(20, n);
    chk("restart_ign", 3 + n, 32'd8);

    // LEN write during pulse only affects the next one
    wr(ADDR_LEN, 32'd4);
    wr(ADDR_CTRL, 32'd1);
    wr(ADDR_LEN, 32'd2);
    measure(20, n);
    chk("lenwr_cur", 1 + n, 32'd4);
    rd("lenwr_rd", ADDR_LEN, 32'd2);
    wr(ADDR_CTRL, 32'd1);
    measure(20, n);
    chk("lenwr_next", n, 32'd2);

    // Abort at pulse cycle 4
    wr(ADDR_STATUS, 32'd2);
    wr(ADDR_LEN, 32'd10);
    wr(ADDR_CTRL, 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_pre", {31'd0, out_port}, 32'd0);
    wr(ADDR_CTRL, 32'd2);
    chk("abort_out", {31'd0, out_port}, 32'd1);
    rd("abort_stat", ADDR_STATUS, 32'd0);

    // DATA=0 written mid-pulse keeps out_port low afterwards
    wr(ADDR_LEN, 32'd4);
    wr(ADDR_CTRL, 32'd1);
    wr(ADDR_DATA, 32'd0);
    repeat (5) @(negedge clk);
    chk("dmid_out", {31'd0, out_port}, 32'd0);
    rd("dmid_data", ADDR_DATA, 32'd0);
    rd("dmid_stat", ADDR_STATUS, 32'd2);

    // DONE clear coincident with the final pulse edge: set wins
    wr(ADDR_STATUS, 32'd2);
    wr(ADDR_DATA, 32'd1);
    wr(ADDR_LEN, 32'd3);
    wr(ADDR_CTRL, 32'd1);
    repeat (2) @(negedge clk);
    wr(ADDR_STATUS, 32'd2);
    chk("coll_out", {31'd0, out_port}, 32'd1);
    rd("coll_stat", ADDR_STATUS, 32'd2);

    // reset at pulse cycle 3
    wr(ADDR_LEN, 32'd10);
    wr(ADDR_CTRL, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_out", {31'd0, out_port}, 32'd0);
    chk("mrst_rdata", bus.readdata, 32'd0);
    rd("mrst_len",  ADDR_LEN,    32'd16);
    rd("mrst_stat", ADDR_STATUS, 32'd0);
    rd("mrst_data", ADDR_DATA,   32'd0);

    // Maximum length pulse
    wr(ADDR_DATA, 32'd1);
    wr(ADDR_LEN, 32'h0000FFFF);
    wr(ADDR_CTRL, 32'd1);
    measure(66000, n);
    chk("max_pulse", n, 32'd65535);
    rd("max_stat", ADDR_STATUS, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
